// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and hazard-decision helpers for hazard_ctrl and hazard_mdu_timer.
package hazard_ctrl_pkg;

    localparam logic [1:0]  TUSE_NONE       = 2'd3;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_M    = 2'd1,
        FWD_W    = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_start_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } e_stage_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rt;
    } m_stage_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] wa;
    } w_stage_t;

    function automatic logic reg_match(input logic valid, input logic [4:0] wa,
                                       input logic [4:0] r);
        return valid && (r != 5'd0) && (wa == r);
    endfunction

    // The youngest producer decides; an older copy behind it holds a stale value.
    function automatic logic src_stall(input logic e_hit, input logic [1:0] e_tnew,
                                       input logic m_hit, input logic [1:0] m_tnew,
                                       input logic [1:0] tuse);
        if (tuse == TUSE_NONE) return 1'b0;
        if (e_hit) return e_tnew > tuse;
        if (m_hit) return m_tnew > tuse;
        return 1'b0;
    endfunction

    function automatic logic [1:0] e_fwd(input logic m_hit, input logic [1:0] m_tnew,
                                         input logic w_hit);
        if (m_hit) return (m_tnew == 2'd0) ? FWD_M : FWD_NONE;
        if (w_hit) return FWD_W;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_mdu_timer.sv
// Busy-window counter for the multiply/divide unit; loads on an MDU op entering E.
module hazard_mdu_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] md_start,
    output logic       busy
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count_q;

    // A new operation restarts the window even if the previous one is still counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load && (md_start != MD_NONE)) begin
            count_q <= (md_start == MD_MULT) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign busy = (count_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for the five-stage MIPS pipeline.
// Define HAZARD_MDU_EN to include the multiply/divide busy window and its stall.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic [1:0] d_md_start,
    output logic       stall,
    output logic       fwd_d_rs_sel,
    output logic       fwd_d_rt_sel,
    output logic [1:0] fwd_e_rs_sel,
    output logic [1:0] fwd_e_rt_sel,
    output logic       fwd_m_rt_sel,
    output logic       mdu_busy
);

    e_stage_t e_q;
    m_stage_t m_q;
    w_stage_t w_q;

    logic rs_stall, rt_stall, md_stall;
    logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;

    // A stalled D instruction stays put, so E receives a bubble that can never match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q.valid <= 1'b1;
                e_q.wa    <= d_wa;
                e_q.tnew  <= (d_tnew == 2'd0) ? 2'd1 : d_tnew;
                e_q.rs    <= d_rs;
                e_q.rt    <= d_rt;
            end
            m_q.valid <= e_q.valid;
            m_q.wa    <= e_q.wa;
            m_q.tnew  <= (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
            m_q.rt    <= e_q.rt;
            w_q.valid <= m_q.valid;
            w_q.wa    <= m_q.wa;
        end
    end

    assign e_hit_rs = reg_match(e_q.valid, e_q.wa, d_rs);
    assign e_hit_rt = reg_match(e_q.valid, e_q.wa, d_rt);
    assign m_hit_rs = reg_match(m_q.valid, m_q.wa, d_rs);
    assign m_hit_rt = reg_match(m_q.valid, m_q.wa, d_rt);

    assign rs_stall = src_stall(e_hit_rs, e_q.tnew, m_hit_rs, m_q.tnew, d_tuse_rs);
    assign rt_stall = src_stall(e_hit_rt, e_q.tnew, m_hit_rt, m_q.tnew, d_tuse_rt);
    assign stall    = rs_stall | rt_stall | md_stall;

    // W results reach D through the register file's own write-through path.
    assign fwd_d_rs_sel = !e_hit_rs && m_hit_rs && (m_q.tnew == 2'd0);
    assign fwd_d_rt_sel = !e_hit_rt && m_hit_rt && (m_q.tnew == 2'd0);

    assign fwd_e_rs_sel = e_fwd(reg_match(m_q.valid, m_q.wa, e_q.rs), m_q.tnew,
                                reg_match(w_q.valid, w_q.wa, e_q.rs));
    assign fwd_e_rt_sel = e_fwd(reg_match(m_q.valid, m_q.wa, e_q.rt), m_q.tnew,
                                reg_match(w_q.valid, w_q.wa, e_q.rt));
    assign fwd_m_rt_sel = reg_match(w_q.valid, w_q.wa, m_q.rt);

`ifdef HAZARD_MDU_EN
    logic [1:0] e_md_q;

    // Remembers which MDU op sits in E, covering the cycle its window opens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_md_q <= MD_NONE;
        end else begin
            e_md_q <= stall ? MD_NONE : d_md_start;
        end
    end

    hazard_mdu_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (!stall),
        .md_start(d_md_start),
        .busy    (mdu_busy)
    );

    assign md_stall = d_md_use && (mdu_busy || (e_md_q != MD_NONE));
`else
    logic unused_md;

    assign unused_md = ^{d_md_use, d_md_start, MULT_CYCLES[0], DIV_CYCLES[0]};
    assign mdu_busy  = 1'b0;
    assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random traffic
// compared every cycle against an instruction-level pipeline model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

`ifdef HAZARD_MDU_EN
    localparam bit MDU_ON = 1'b1;
`else
    localparam bit MDU_ON = 1'b0;
`endif
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_start;
    logic       d_md_use;
    logic       stall, fwd_d_rs_sel, fwd_d_rt_sel, fwd_m_rt_sel, mdu_busy;
    logic [1:0] fwd_e_rs_sel, fwd_e_rt_sel;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // One instruction as it travels E (0), M (1), W (2); tnew is its value on entering E.
    typedef struct {
        bit valid;
        int wa;
        int tnew;
        int rs;
        int rt;
        int md;
    } inst_t;

    inst_t pipe[3];
    int    edgeCount;
    int    busyUntil;

    hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk         (clk),
        .reset       (reset),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_wa        (d_wa),
        .d_tnew      (d_tnew),
        .d_md_use    (d_md_use),
        .d_md_start  (d_md_start),
        .stall       (stall),
        .fwd_d_rs_sel(fwd_d_rs_sel),
        .fwd_d_rt_sel(fwd_d_rt_sel),
        .fwd_e_rs_sel(fwd_e_rs_sel),
        .fwd_e_rt_sel(fwd_e_rt_sel),
        .fwd_m_rt_sel(fwd_m_rt_sel),
        .mdu_busy    (mdu_busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int remaining(int k);
        int t;
        t = pipe[k].tnew - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int youngest(int r, int first, int last);
        for (int k = first; k <= last; k++)
            if (r != 0 && pipe[k].valid && pipe[k].wa == r) return k;
        return -1;
    endfunction

    function automatic bit srcStall(int r, int tuse);
        int k;
        if (tuse == 3) return 1'b0;
        k = youngest(r, 0, 1);
        if (k < 0) return 1'b0;
        return remaining(k) > tuse;
    endfunction

    function automatic bit mdBusy();
        return MDU_ON && (edgeCount < busyUntil);
    endfunction

    function automatic bit expStall();
        return srcStall(int'(d_rs), int'(d_tuse_rs)) || srcStall(int'(d_rt), int'(d_tuse_rt)) ||
               (MDU_ON && d_md_use && (mdBusy() || pipe[0].md != 0));
    endfunction

    function automatic int expDFwd(int r);
        return (youngest(r, 0, 1) == 1 && remaining(1) == 0) ? 1 : 0;
    endfunction

    function automatic int expEFwd(int r);
        int k;
        k = youngest(r, 1, 2);
        if (k == 1) return (remaining(1) == 0) ? 1 : 0;
        if (k == 2) return 2;
        return 0;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
        edgeCount = 0;
        busyUntil = 0;
    endtask

    task automatic modelAdvance();
        inst_t nxt;
        bit    s;
        if (reset) begin
            modelReset();
            return;
        end
        s   = expStall();
        nxt = '{default: 0};
        if (!s) begin
            nxt.valid = 1'b1;
            nxt.wa    = int'(d_wa);
            nxt.tnew  = (d_tnew == 2'd0) ? 1 : int'(d_tnew);
            nxt.rs    = int'(d_rs);
            nxt.rt    = int'(d_rt);
            nxt.md    = int'(d_md_start);
        end
        edgeCount++;
        if (!s && MDU_ON && d_md_start != 2'd0)
            busyUntil = edgeCount + ((d_md_start == 2'd1) ? MULT_N : DIV_N);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
    endtask

    always @(posedge clk) modelAdvance();

    // ---------------- checking ----------------
    task automatic compare(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        compare("stall",    int'(stall),        int'(expStall()));
        compare("fwd_d_rs", int'(fwd_d_rs_sel), expDFwd(int'(d_rs)));
        compare("fwd_d_rt", int'(fwd_d_rt_sel), expDFwd(int'(d_rt)));
        compare("fwd_e_rs", int'(fwd_e_rs_sel), expEFwd(pipe[0].rs));
        compare("fwd_e_rt", int'(fwd_e_rt_sel), expEFwd(pipe[0].rt));
        compare("fwd_m_rt", int'(fwd_m_rt_sel), (youngest(pipe[1].rt, 2, 2) == 2) ? 1 : 0);
        compare("mdu_busy", int'(mdu_busy),     int'(mdBusy()));
    endtask

    always @(negedge clk) if (checkEn) checkOutput();

    // ---------------- stimulus ----------------
    task automatic applyStimulus(int rs, int tuseRs, int rt, int tuseRt, int wa, int tnew,
                                 int mdUse, int mdStart);
        @(posedge clk);
        #1;
        d_rs       = 5'(rs);
        d_tuse_rs  = 2'(tuseRs);
        d_rt       = 5'(rt);
        d_tuse_rt  = 2'(tuseRt);
        d_wa       = 5'(wa);
        d_tnew     = 2'(tnew);
        d_md_use   = mdUse[0];
        d_md_start = 2'(mdStart);
    endtask

    task automatic nop(int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 3, 0, 3, 0, 1, 0, 0);
    endtask

    task automatic mdStallCount(string name, int mdStart, int expCycles);
        int n;
        applyStimulus(0, 3, 0, 3, 0, 1, 1, mdStart);
        applyStimulus(0, 3, 0, 3, 12, 1, 1, 0);
        #2;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            applyStimulus(0, 3, 0, 3, 12, 1, 1, 0);
            #2;
        end
        compare(name, n, expCycles);
        compare({name, "_busy_clear"}, int'(mdu_busy), 0);
        nop(3);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        reset      = 1'b1;
        d_rs       = '0;
        d_rt       = '0;
        d_wa       = '0;
        d_tuse_rs  = 2'd3;
        d_tuse_rt  = 2'd3;
        d_tnew     = 2'd1;
        d_md_use   = 1'b0;
        d_md_start = 2'd0;
        #2;
        compare("reset_stall",    int'(stall),        0);
        compare("reset_fwd_e_rs", int'(fwd_e_rs_sel), 0);
        compare("reset_busy",     int'(mdu_busy),     0);
        @(posedge clk);
        #1 reset = 1'b0;
        checkEn = 1'b1;
        nop(2);

        // load-use: one stall, then forward from W into E
        applyStimulus(0, 3, 0, 3, 8, 2, 0, 0);
        applyStimulus(8, 1, 0, 3, 10, 1, 0, 0);
        #2 compare("lw_use_stall", int'(stall), 1);
        applyStimulus(8, 1, 0, 3, 10, 1, 0, 0);
        #2 compare("lw_use_release", int'(stall), 0);
        nop(1);
        #2 compare("lw_use_fwd_e_rs", int'(fwd_e_rs_sel), 2);
        nop(3);

        // ALU result feeding a branch in D
        applyStimulus(0, 3, 0, 3, 9, 1, 0, 0);
        applyStimulus(9, 0, 0, 3, 0, 1, 0, 0);
        #2 compare("alu_br_stall", int'(stall), 1);
        applyStimulus(9, 0, 0, 3, 0, 1, 0, 0);
        #2 compare("alu_br_release", int'(stall), 0);
        compare("alu_br_fwd_d_rs", int'(fwd_d_rs_sel), 1);
        nop(3);

        // register 0 never hazards
        applyStimulus(0, 3, 0, 3, 0, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        #2 compare("r0_stall", int'(stall), 0);
        compare("r0_fwd_d_rt", int'(fwd_d_rt_sel), 0);
        nop(1);
        #2 compare("r0_fwd_e_rs", int'(fwd_e_rs_sel), 0);
        nop(3);

        // two writers of $5: the younger M copy wins
        applyStimulus(0, 3, 0, 3, 5, 1, 0, 0);
        applyStimulus(0, 3, 0, 3, 5, 1, 0, 0);
        applyStimulus(5, 1, 0, 3, 0, 1, 0, 0);
        #2 compare("dup_wr_stall", int'(stall), 0);
        nop(1);
        #2 compare("dup_wr_fwd_e_rs", int'(fwd_e_rs_sel), 1);
        nop(3);

        // load then store of the loaded value: data picked up from W in M
        applyStimulus(0, 3, 0, 3, 6, 2, 0, 0);
        applyStimulus(0, 3, 6, 2, 0, 1, 0, 0);
        #2 compare("ld_st_stall", int'(stall), 0);
        nop(1);
        #2 compare("ld_st_fwd_e_rt", int'(fwd_e_rt_sel), 0);
        nop(1);
        #2 compare("ld_st_fwd_m_rt", int'(fwd_m_rt_sel), 1);
        nop(3);

        mdStallCount("mult_stall_cycles", 1, MDU_ON ? MULT_N : 0);
        mdStallCount("div_stall_cycles",  2, MDU_ON ? DIV_N : 0);

        // reset while a divide has six cycles left
        applyStimulus(0, 3, 0, 3, 0, 1, 1, 2);
        nop(4);
        applyStimulus(0, 3, 0, 3, 12, 1, 1, 0);
        #2 compare("div_mid_stall", int'(stall), MDU_ON ? 1 : 0);
        reset = 1'b1;
        modelReset();
        #1;
        compare("rst_mid_busy",  int'(mdu_busy), 0);
        compare("rst_mid_stall", int'(stall),    0);
        @(posedge clk);
        #1 reset = 1'b0;
        #2 compare("rst_mflo_stall", int'(stall), 0);
        nop(2);

        // random traffic over a small register set to provoke many hazards
        for (int i = 0; i < 2000; i++) begin
            int mdStart;
            mdStart = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2)) : 0;
            applyStimulus(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                          (mdStart != 0 || $urandom_range(0, 7) == 0) ? 1 : 0, mdStart);
        end
        nop(2);
        @(negedge clk);
        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
